efi_args_buffer: RTL and testbench
==================================

EFI_ARGS_BUFFER -- requirements
Module: efi_args_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the argument word width.
REQ-002 SHALL have parameter DEST_WIDTH, default 8, meaning the tdest width.
REQ-003 SHALL have parameter USER_WIDTH, default 1, meaning the tuser width.
REQ-004 SHALL have parameter MAX_LENGTH, default 256, meaning the maximum number of beats per packet (power of 2).
REQ-005 SHALL have port clock, input, 1, the single clock; all logic is synchronous to it.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port efi_arguments_in, axi_stream slave, carrying fCore arguments (data, dest, user, tlast).
REQ-008 SHALL have port efi_arguments_out, axi_stream master, feeding the downstream EFI (e.g. efi_sorter).
REQ-009 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-010 SHALL have port packet_length, output, $clog2(MAX_LENGTH)+1, beat count of the packet currently being drained or last drained.
REQ-011 SHALL have port overflow, output, 1, sticky flag for a packet that exceeded MAX_LENGTH.

Function
REQ-012 SHALL act as a store-and-forward buffer: no output beat before the input tlast beat is accepted.
REQ-013 SHALL implement FSM states IDLE, FILL, DISCARD, DRAIN.
REQ-014 IDLE: in.ready=1; an accepted beat without tlast -> FILL; with tlast -> DRAIN (length 1).
REQ-015 FILL: in.ready=1; each accepted beat is written at wr_ptr, then wr_ptr increments; a tlast beat -> DRAIN.
REQ-016 SHALL latch tdest from the first beat of a packet and present it on every output beat; tuser SHALL be stored per beat.
REQ-017 DRAIN: in.ready=0; out.valid SHALL rise in the second cycle after the input tlast handshake (one-cycle RAM prefetch).
REQ-018 Output data, user, and dest SHALL stay stable while out.valid=1 and out.ready=0.
REQ-019 out.tlast SHALL be 1 only on beat packet_length-1.
REQ-020 After the tlast output handshake: out.valid=0 next cycle, pointers cleared, FSM -> IDLE, in.ready=1 that same next cycle.
REQ-021 Full throughput: with out.ready held 1, one beat SHALL be emitted per cycle once valid rises.
REQ-022 packet_length SHALL update on the input tlast handshake and hold until the next one.

Reset
REQ-023 On reset low: FSM=IDLE, pointers=0, out.valid=0, out.tlast=0, out.data=0, busy=0, packet_length=0, overflow=0, in.ready=0 while reset is asserted.
REQ-024 Reset mid-packet SHALL discard all buffered beats; no partial packet is ever emitted afterwards.
REQ-025 RAM contents need not be reset.

Configuration
REQ-026 Macro EFI_ARGS_BUFFER_LENGTH_CHECK_EN: when defined, the MAX_LENGTH-th beat without tlast SHALL set overflow, end the packet (length=MAX_LENGTH), and enter DISCARD.
REQ-027 In DISCARD: in.ready=1, beats are dropped until the input tlast beat, then -> DRAIN.
REQ-028 When the macro is undefined: no DISCARD state; overflow tied 0; wr_ptr wraps modulo MAX_LENGTH, and packets longer than MAX_LENGTH are the caller's error.

Structure
REQ-029 The FSM state enum typedef and the default width constants SHALL live in shared package efi_pkg.
REQ-030 Storage SHALL be sub-module efi_buffer_ram: simple dual-port, 1 write port, 1 registered read port, depth MAX_LENGTH, width DATA_WIDTH+USER_WIDTH.

Verification
REQ-031 5 beats 1,2,3,4,5 (dest 8, tlast on 5), out.ready=1 -> no output before tlast; outputs 1..5 on consecutive cycles, dest 8, tlast only on 5, packet_length=5.
REQ-032 Single beat 0xDEADBEEF with tlast from IDLE -> one output beat 0xDEADBEEF with tlast; busy returns to 0.
REQ-033 4-beat packet drained with out.ready toggling 1/0 each cycle -> output beats are held stable while stalled, with no loss or duplication; in.ready=0 until the last output beat is accepted.
REQ-034 Reset asserted after the 3rd of 6 input beats, then a 2-beat packet 7,9 -> only 7,9 are emitted; overflow=0.
REQ-035 With the macro defined and MAX_LENGTH=8, a 12-beat packet -> beats 1..8 are emitted with tlast on 8; overflow=1 (sticky); packet_length=8; beats 9..12 are dropped.
REQ-036 Back-to-back packets of lengths 3 and 2 -> the second packet's first beat is accepted the cycle after the first packet's tlast output handshake, and both packets are emitted intact.

Source files
------------

// File: rtl/efi_pkg.sv
// Shared definitions for the EFI argument buffer: default widths and the FSM state type.
// EFI_ARGS_BUFFER_LENGTH_CHECK_EN adds the StDiscard state used by the overflow check.
package efi_pkg;

  localparam int unsigned EfiDataWidth = 32;
  localparam int unsigned EfiDestWidth = 8;
  localparam int unsigned EfiUserWidth = 1;
  localparam int unsigned EfiMaxLength = 256;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFill    = 2'd1,
`ifdef EFI_ARGS_BUFFER_LENGTH_CHECK_EN
    StDiscard = 2'd2,
`endif
    StDrain   = 2'd3
  } efi_state_e;

endpackage

// File: rtl/efi_buffer_ram.sv
// Simple dual-port packet store: one write port, one registered read port with enable.
// The read register holds its value when re_i is low, which keeps stalled output beats stable.
module efi_buffer_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 33,
  localparam int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the read register is reset so the output bus reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/efi_args_buffer.sv
// Store-and-forward buffer for fCore arguments: a whole packet is captured, then drained.
// EFI_ARGS_BUFFER_LENGTH_CHECK_EN enables the MAX_LENGTH overflow check and DISCARD state.
module efi_args_buffer
  import efi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = EfiDataWidth,
  parameter int unsigned DEST_WIDTH = EfiDestWidth,
  parameter int unsigned USER_WIDTH = EfiUserWidth,
  parameter int unsigned MAX_LENGTH = EfiMaxLength,
  localparam int unsigned LenWidth = $clog2(MAX_LENGTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  efi_arguments_in_tvalid,
  output logic                  efi_arguments_in_tready,
  input  logic [DATA_WIDTH-1:0] efi_arguments_in_tdata,
  input  logic [DEST_WIDTH-1:0] efi_arguments_in_tdest,
  input  logic [USER_WIDTH-1:0] efi_arguments_in_tuser,
  input  logic                  efi_arguments_in_tlast,
  output logic                  efi_arguments_out_tvalid,
  input  logic                  efi_arguments_out_tready,
  output logic [DATA_WIDTH-1:0] efi_arguments_out_tdata,
  output logic [DEST_WIDTH-1:0] efi_arguments_out_tdest,
  output logic [USER_WIDTH-1:0] efi_arguments_out_tuser,
  output logic                  efi_arguments_out_tlast,
  output logic                  busy,
  output logic [LenWidth-1:0]   packet_length,
  output logic                  overflow
);

  localparam int unsigned AddrWidth = $clog2(MAX_LENGTH);
  localparam int unsigned RamWidth  = DATA_WIDTH + USER_WIDTH;

  efi_state_e            state_q, state_d;
  logic [AddrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LenWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  in_fire, ram_we, ram_re;
  logic [RamWidth-1:0]   ram_rdata;
`ifdef EFI_ARGS_BUFFER_LENGTH_CHECK_EN
  logic                  ovf_q, ovf_d;
`endif

  assign in_fire = efi_arguments_in_tvalid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    dest_d      = dest_q;
    out_valid_d = out_valid_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
`ifdef EFI_ARGS_BUFFER_LENGTH_CHECK_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      StIdle, StFill: begin
        if (in_fire) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AddrWidth'(1);
          if (state_q == StIdle) begin
            dest_d = efi_arguments_in_tdest;
          end
          if (efi_arguments_in_tlast) begin
            len_d   = LenWidth'(wr_ptr_q) + LenWidth'(1);
            state_d = StDrain;
`ifdef EFI_ARGS_BUFFER_LENGTH_CHECK_EN
          end else if (wr_ptr_q == AddrWidth'(MAX_LENGTH - 1)) begin
            ovf_d   = 1'b1;
            len_d   = LenWidth'(MAX_LENGTH);
            state_d = StDiscard;
`endif
          end else begin
            state_d = StFill;
          end
        end
      end
`ifdef EFI_ARGS_BUFFER_LENGTH_CHECK_EN
      StDiscard: begin
        if (in_fire && efi_arguments_in_tlast) begin
          state_d = StDrain;
        end
      end
`endif
      StDrain: begin
        // rd_ptr_q points one past the beat held in the RAM read register.
        if (!out_valid_q) begin
          ram_re      = 1'b1;
          rd_ptr_d    = rd_ptr_q + LenWidth'(1);
          out_valid_d = 1'b1;
        end else if (efi_arguments_out_tready) begin
          if (rd_ptr_q == len_q) begin
            out_valid_d = 1'b0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            state_d     = StIdle;
          end else begin
            ram_re   = 1'b1;
            rd_ptr_d = rd_ptr_q + LenWidth'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    in_ready_d = (state_d != StDrain);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      dest_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      dest_q      <= dest_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef EFI_ARGS_BUFFER_LENGTH_CHECK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  efi_buffer_ram #(
    .Depth (MAX_LENGTH),
    .Width (RamWidth)
  ) u_ram (
    .clk_i   (clock),
    .rst_ni  (reset),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({efi_arguments_in_tuser, efi_arguments_in_tdata}),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[AddrWidth-1:0]),
    .rdata_o (ram_rdata)
  );

  assign efi_arguments_in_tready  = in_ready_q;
  assign efi_arguments_out_tvalid = out_valid_q;
  assign efi_arguments_out_tdata  = ram_rdata[DATA_WIDTH-1:0];
  assign efi_arguments_out_tuser  = ram_rdata[RamWidth-1:DATA_WIDTH];
  assign efi_arguments_out_tdest  = dest_q;
  assign efi_arguments_out_tlast  = out_valid_q && (rd_ptr_q == len_q);
  assign busy                     = (state_q != StIdle);
  assign packet_length            = len_q;

endmodule

// File: tb/tb_efi_args_buffer.sv
// Directed bench for efi_args_buffer: a packet table plus hand-written reset sequences.
// The overflow packets run only when EFI_ARGS_BUFFER_LENGTH_CHECK_EN is defined.
module tb_efi_args_buffer;

  localparam int unsigned DW = 32;
  localparam int unsigned DSW = 8;
  localparam int unsigned UW = 1;
  localparam int unsigned ML = 8;
  localparam int unsigned LW = $clog2(ML) + 1;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  in_data = '0;
  logic [DSW-1:0] in_dest = '0;
  logic [UW-1:0]  in_user = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  out_data;
  logic [DSW-1:0] out_dest;
  logic [UW-1:0]  out_user;
  logic           out_last;
  logic           busy;
  logic [LW-1:0]  packet_length;
  logic           overflow;

  always #5 clock = ~clock;

  efi_args_buffer #(
    .DATA_WIDTH (DW),
    .DEST_WIDTH (DSW),
    .USER_WIDTH (UW),
    .MAX_LENGTH (ML)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .efi_arguments_in_tvalid  (in_valid),
    .efi_arguments_in_tready  (in_ready),
    .efi_arguments_in_tdata   (in_data),
    .efi_arguments_in_tdest   (in_dest),
    .efi_arguments_in_tuser   (in_user),
    .efi_arguments_in_tlast   (in_last),
    .efi_arguments_out_tvalid (out_valid),
    .efi_arguments_out_tready (out_ready),
    .efi_arguments_out_tdata  (out_data),
    .efi_arguments_out_tdest  (out_dest),
    .efi_arguments_out_tuser  (out_user),
    .efi_arguments_out_tlast  (out_last),
    .busy                     (busy),
    .packet_length            (packet_length),
    .overflow                 (overflow)
  );

  typedef struct {
    int unsigned n_in;
    int unsigned exp_len;
    logic [31:0] d0;
    logic [31:0] step;
    logic [7:0]  dest;
    bit          toggle;
    bit          b2b;
    bit          exp_ovf;
  } vec_t;

  vec_t        vecs[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void add_vec(input int unsigned n_in, input int unsigned exp_len,
                                  input logic [31:0] d0, input logic [31:0] step,
                                  input logic [7:0] dest, input bit toggle, input bit b2b,
                                  input bit exp_ovf);
    vec_t v;
    v.n_in = n_in; v.exp_len = exp_len; v.d0 = d0; v.step = step; v.dest = dest;
    v.toggle = toggle; v.b2b = b2b; v.exp_ovf = exp_ovf;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_tlast"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_packet_length"}, packet_length, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  // Presents one beat and returns after the edge that accepts it.
  task automatic send_beat(input logic [31:0] d, input logic [7:0] dst, input logic u,
                           input logic last, output int unsigned waits);
    in_valid = 1'b1; in_data = d; in_dest = dst; in_user = u; in_last = last;
    waits = 0;
    while (!in_ready && waits < 50) begin
      tick();
      waits++;
    end
    if (waits >= 50) chk("in_accept_timeout", 64'(waits), 64'd0);
    chk("no_early_output", out_valid, 0);
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned waits, beat, k;
    logic [31:0] h_data;
    logic [7:0]  h_dest;
    logic        h_user, h_last;
    bit          held;
    for (int i = 0; i < int'(v.n_in); i++) begin
      send_beat(v.d0 + v.step * 32'(i), v.dest + 8'(i), 1'(i), i == int'(v.n_in) - 1, waits);
      if (i == 0 && v.b2b) chk("b2b_first_accept_wait", 64'(waits), 64'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("prefetch_valid_low", out_valid, 0);
    chk("drain_in_ready_low", in_ready, 0);
    chk("drain_busy", busy, 1);
    chk("packet_length", packet_length, 64'(v.exp_len));
    chk("overflow", overflow, 64'(v.exp_ovf));
    out_ready = 1'b1;
    tick();
    chk("valid_second_cycle", out_valid, 1);
    beat = 0; k = 0; held = 0;
    h_data = '0; h_dest = '0; h_user = 1'b0; h_last = 1'b0;
    while (beat < v.exp_len && k < 200) begin
      if (out_valid) begin
        if (held) begin
          chk("stall_data", out_data, h_data);
          chk("stall_dest", out_dest, h_dest);
          chk("stall_user", out_user, h_user);
          chk("stall_tlast", out_last, h_last);
        end
        if (out_ready) begin
          chk("out_data", out_data, v.d0 + v.step * beat);
          chk("out_dest", out_dest, v.dest);
          chk("out_user", out_user, 1'(beat));
          chk("out_tlast", out_last, beat == v.exp_len - 1);
          chk("in_ready_low_in_drain", in_ready, 0);
          beat++;
          held = 0;
        end else begin
          h_data = out_data; h_dest = out_dest; h_user = out_user; h_last = out_last;
          held = 1;
        end
      end else if (!v.toggle) begin
        chk("throughput_gap", out_valid, 1);
      end
      tick();
      k++;
      out_ready = v.toggle ? ~out_ready : 1'b1;
    end
    if (beat < v.exp_len) chk("drain_timeout", 64'(beat), 64'(v.exp_len));
    out_ready = 1'b0;
    chk("valid_low_after_last", out_valid, 0);
    chk("in_ready_after_last", in_ready, 1);
    chk("busy_after_last", busy, 0);
    chk("packet_length_hold", packet_length, 64'(v.exp_len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned waits;
    vec_t v;
    add_vec(5, 5, 32'd1, 32'd1, 8'd8, 1'b0, 1'b0, 1'b0);
    add_vec(1, 1, 32'hDEAD_BEEF, 32'd0, 8'h3C, 1'b0, 1'b1, 1'b0);
    add_vec(4, 4, 32'h100, 32'h11, 8'hA5, 1'b1, 1'b1, 1'b0);
    add_vec(3, 3, 32'h2000, 32'h3, 8'h10, 1'b0, 1'b1, 1'b0);
    add_vec(2, 2, 32'h3000, 32'h5, 8'h20, 1'b0, 1'b1, 1'b0);
`ifdef EFI_ARGS_BUFFER_LENGTH_CHECK_EN
    add_vec(12, 8, 32'd1, 32'd1, 8'h44, 1'b0, 1'b1, 1'b1);
    add_vec(2, 2, 32'h77, 32'h1, 8'h45, 1'b0, 1'b1, 1'b1);
`endif

    tick(); tick(); tick();
    check_reset_state("por");
    reset = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset after 3 of 6 input beats; the partial packet must never appear.
    for (int i = 0; i < 3; i++) begin
      send_beat(32'h500 + 32'(i), 8'h66, 1'b0, 1'b0, waits);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_state("midpkt");
    tick(); tick();
    reset = 1'b1;
    v.n_in = 2; v.exp_len = 2; v.d0 = 32'd7; v.step = 32'd2; v.dest = 8'h55;
    v.toggle = 1'b0; v.b2b = 1'b0; v.exp_ovf = 1'b0;
    run_vec(v);
    chk("overflow_after_reset", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
